// File: rtl/switch_allocator_pkg.sv
// Shared constants, output-lock state type and encoding helper for the 5x5 router switch allocator.
package switch_allocator_pkg;

  localparam int unsigned SA_PORT_NUM = 5;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_e;

  // Relative one-hot encoding skips the self port: bit index that input j uses to reach output o.
  function automatic int unsigned sel_bit(input int unsigned j, input int unsigned o);
    return (j < o) ? o - 1 : o;
  endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, wrapping at N-1.
module sw_rr_arbiter #(
  parameter int unsigned N  = 5,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-cycle switch allocator: per-output round-robin arbitration with wormhole locking, driving
// the crossbar's relative one-hot port_sel rows and per-input pop grants.
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int unsigned PORT_NUM             = SA_PORT_NUM,
  parameter int unsigned PORT_SEL_WIDTH       = PORT_NUM - 1,
  parameter int unsigned PORT_NUM_BCD_WIDTH   = $clog2(PORT_NUM),
  parameter int unsigned PORT_SEL_ARRAY_WIDTH = PORT_SEL_WIDTH * PORT_NUM
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [PORT_NUM-1:0]             req_array,
  input  logic [PORT_NUM-1:0]             hdr_array,
  input  logic [PORT_NUM-1:0]             tail_array,
  input  logic [PORT_SEL_ARRAY_WIDTH-1:0] dest_sel_array,
  input  logic [PORT_NUM-1:0]             out_ready_array,
  output logic [PORT_NUM-1:0]             grant_array,
  output logic [PORT_SEL_ARRAY_WIDTH-1:0] port_sel_array,
  output logic [PORT_NUM-1:0]             out_valid_array,
  output logic [PORT_NUM-1:0]             out_locked_array,
  output logic                            dest_err
);

  localparam int unsigned BW = PORT_NUM_BCD_WIDTH;

  function automatic logic [BW-1:0] next_idx(input logic [BW-1:0] i);
    return (i == BW'(PORT_NUM - 1)) ? '0 : i + 1'b1;
  endfunction

  logic [PORT_NUM-1:0]          dest_onehot;
  logic [PORT_NUM-1:0]          valid_req;
  logic [PORT_NUM-1:0]          bad_req;
  logic [PORT_NUM*PORT_NUM-1:0] gnt_flat;
  logic [PORT_NUM-1:0]          grant_raw;
  logic [PORT_NUM-1:0]          out_valid_raw;
  logic                         dest_err_q, dest_err_d;

  always_comb begin
    dest_onehot = '0;
    for (int unsigned j = 0; j < PORT_NUM; j++)
      dest_onehot[j] = $onehot(dest_sel_array[j*PORT_SEL_WIDTH +: PORT_SEL_WIDTH]);
  end

  assign valid_req = req_array & dest_onehot;
  assign bad_req   = req_array & ~dest_onehot;

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    logic [PORT_NUM-1:0] to_o;
    logic [PORT_NUM-1:0] hdr_cand;
    logic [PORT_NUM-1:0] arb_gnt;
    logic [PORT_NUM-1:0] gnt;
    logic [BW-1:0]       win_idx;
    out_state_e          state_q, state_d;
    logic [BW-1:0]       owner_q, owner_d;
    logic [BW-1:0]       ptr_q, ptr_d;

    // Self bit stays 0, which also keeps the arbiter from ever choosing input o.
    always_comb begin
      to_o = '0;
      for (int unsigned j = 0; j < PORT_NUM; j++)
        if (j != o)
          to_o[j] = valid_req[j] & dest_sel_array[j*PORT_SEL_WIDTH + sel_bit(j, o)];
    end

    assign hdr_cand = to_o & hdr_array;

    sw_rr_arbiter #(
      .N (PORT_NUM),
      .PW(BW)
    ) u_arb (
      .req_i  (hdr_cand),
      .ptr_i  (ptr_q),
      .grant_o(arb_gnt)
    );

    always_comb begin
      gnt     = '0;
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      win_idx = '0;
      for (int unsigned j = 0; j < PORT_NUM; j++)
        if (arb_gnt[j]) win_idx = BW'(j);
      unique case (state_q)
        OUT_IDLE: begin
          if (out_ready_array[o] && |arb_gnt) begin
            gnt = arb_gnt;
            if (tail_array[win_idx]) begin
              ptr_d = next_idx(win_idx);
            end else begin
              state_d = OUT_LOCKED;
              owner_d = win_idx;
            end
          end
        end
        OUT_LOCKED: begin
          if (out_ready_array[o] && to_o[owner_q]) begin
            gnt[owner_q] = 1'b1;
            if (tail_array[owner_q]) begin
              state_d = OUT_IDLE;
              ptr_d   = next_idx(owner_q);
            end
          end
        end
        default: state_d = OUT_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= OUT_IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end
    end

    assign gnt_flat[o*PORT_NUM +: PORT_NUM] = gnt;
    assign out_valid_raw[o]                 = |gnt;
    assign out_locked_array[o]              = (state_q == OUT_LOCKED);
  end

  // Each input targets one output at most, so OR-ing the per-output grants never collides.
  always_comb begin
    grant_raw = '0;
    for (int unsigned o = 0; o < PORT_NUM; o++)
      grant_raw = grant_raw | gnt_flat[o*PORT_NUM +: PORT_NUM];
  end

  assign grant_array     = reset ? grant_raw : '0;
  assign out_valid_array = reset ? out_valid_raw : '0;

  always_comb begin
    port_sel_array = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++)
      if (grant_array[i])
        port_sel_array[i*PORT_SEL_WIDTH +: PORT_SEL_WIDTH] =
          dest_sel_array[i*PORT_SEL_WIDTH +: PORT_SEL_WIDTH];
  end

  assign dest_err_d = dest_err_q | (|bad_req);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dest_err_q <= 1'b0;
    else        dest_err_q <= dest_err_d;
  end

  assign dest_err = dest_err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a packet-level reference model.
module tb_switch_allocator;

  localparam int N  = 5;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0, hdr = '0, tail = '0, ordy = '1;
  logic [N*SW-1:0] dsel = '0;
  logic [N-1:0]    grant, ov, locked;
  logic [N*SW-1:0] psel;
  logic            derr;

  int checks   = 0;
  int failures = 0;

  switch_allocator dut (
    .clk             (clk),
    .reset           (reset),
    .req_array       (req),
    .hdr_array       (hdr),
    .tail_array      (tail),
    .dest_sel_array  (dsel),
    .out_ready_array (ordy),
    .grant_array     (grant),
    .port_sel_array  (psel),
    .out_valid_array (ov),
    .out_locked_array(locked),
    .dest_err        (derr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet-level view of each output (locked owner or round-robin pointer).
  int m_lock[N], m_owner[N], m_ptr[N], m_err;
  int n_lock[N], n_owner[N], n_ptr[N], n_err;
  int tgt[N];
  int w, jj, k;
  logic [N-1:0]    eg, eov, elk;
  logic [N*SW-1:0] eps;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_lock[i] = 0; m_owner[i] = 0; m_ptr[i] = 0;
      n_lock[i] = 0; n_owner[i] = 0; n_ptr[i] = 0;
    end
    m_err = 0;
    n_err = 0;
  end

  always @(negedge clk) begin
    eg = '0; eov = '0; eps = '0; elk = '0;
    for (int o = 0; o < N; o++) begin
      n_lock[o] = m_lock[o]; n_owner[o] = m_owner[o]; n_ptr[o] = m_ptr[o];
      elk[o] = (m_lock[o] != 0);
    end
    n_err = m_err;
    if (!reset) begin
      for (int o = 0; o < N; o++) begin
        n_lock[o] = 0; n_owner[o] = 0; n_ptr[o] = 0;
      end
      n_err = 0;
    end else begin
      for (int j = 0; j < N; j++) begin
        tgt[j] = -1;
        if (req[j]) begin
          if ($countones(dsel[j*SW +: SW]) == 1) begin
            for (k = 0; k < SW; k++)
              if (dsel[j*SW + k]) tgt[j] = (k < j) ? k : k + 1;
          end else begin
            n_err = 1;
          end
        end
      end
      for (int o = 0; o < N; o++) begin
        w = -1;
        if (m_lock[o] != 0) begin
          if (tgt[m_owner[o]] == o && ordy[o]) w = m_owner[o];
        end else if (ordy[o]) begin
          for (int n = 0; n < N; n++) begin
            jj = (m_ptr[o] + n) % N;
            if (w < 0 && tgt[jj] == o && hdr[jj]) w = jj;
          end
        end
        if (w >= 0) begin
          eg[w] = 1'b1;
          eov[o] = 1'b1;
          eps[w*SW +: SW] = dsel[w*SW +: SW];
          if (m_lock[o] == 0) begin
            if (tail[w]) n_ptr[o] = (w + 1) % N;
            else begin n_lock[o] = 1; n_owner[o] = w; end
          end else if (tail[w]) begin
            n_lock[o] = 0;
            n_ptr[o]  = (w + 1) % N;
          end
        end
      end
    end
    chk("model_grant", 32'(grant), 32'(eg));
    chk("model_out_valid", 32'(ov), 32'(eov));
    chk("model_port_sel", 32'(psel), 32'(eps));
    chk("model_out_locked", 32'(locked), 32'(elk));
    chk("model_dest_err", 32'(derr), 32'(m_err != 0));
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < N; o++) begin
        m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
      end
      m_err = 0;
    end else begin
      for (int o = 0; o < N; o++) begin
        m_lock[o] = n_lock[o]; m_owner[o] = n_owner[o]; m_ptr[o] = n_ptr[o];
      end
      m_err = n_err;
    end
  end

  task automatic idle_inputs();
    req = '0; hdr = '0; tail = '0; dsel = '0; ordy = '1;
  endtask

  task automatic set_req(input int j, input int out, input bit h, input bit t);
    int kk;
    kk = (out < j) ? out : out - 1;
    req[j]  = 1'b1;
    hdr[j]  = h;
    tail[j] = t;
    dsel[j*SW +: SW] = 4'(1 << kk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] rot_exp[4];

  initial begin
    // Reset held with every input requesting
    reset = 1'b0;
    req = '1; hdr = '1; tail = '1; dsel = {N{4'b0001}}; ordy = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_port_sel", 32'(psel), 32'h0);
    chk("reset_out_locked", 32'(locked), 32'h0);
    chk("reset_dest_err", 32'(derr), 32'h0);
    reset = 1'b1;

    // Contention on output 0: single-flit packets from inputs 1,2,3
    rot_exp[0] = 5'b00010; rot_exp[1] = 5'b00100; rot_exp[2] = 5'b01000; rot_exp[3] = 5'b00010;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) next_cyc();
      idle_inputs();
      set_req(1, 0, 1, 1); set_req(2, 0, 1, 1); set_req(3, 0, 1, 1);
      #2;
      chk("rr_grant", 32'(grant), 32'(rot_exp[i]));
      chk("rr_out_valid", 32'(ov), 32'h1);
    end

    // Wormhole on output 2: input 4 owns it, input 0 waits for the tail
    next_cyc(); idle_inputs(); set_req(4, 2, 1, 0);
    #2; chk("wh_hdr_grant", 32'(grant), 32'h10); chk("wh_port_sel", 32'(psel), 32'h40000);
    next_cyc(); idle_inputs(); set_req(4, 2, 0, 0); set_req(0, 2, 1, 1);
    #2; chk("wh_body_grant", 32'(grant), 32'h10); chk("wh_locked", 32'(locked), 32'h04);
    next_cyc(); idle_inputs(); set_req(4, 2, 0, 1); set_req(0, 2, 1, 1);
    #2; chk("wh_tail_grant", 32'(grant), 32'h10);
    next_cyc(); idle_inputs(); set_req(0, 2, 1, 1);
    #2; chk("wh_next_grant", 32'(grant), 32'h01); chk("wh_unlocked", 32'(locked), 32'h0);

    // Backpressure on locked output 1
    next_cyc(); idle_inputs(); set_req(3, 1, 1, 0);
    #2; chk("bp_hdr_grant", 32'(grant), 32'h08);
    for (int i = 0; i < 3; i++) begin
      next_cyc(); idle_inputs(); ordy[1] = 1'b0; set_req(3, 1, 0, 0); set_req(0, 1, 1, 1);
      #2; chk("bp_stall_grant", 32'(grant), 32'h0); chk("bp_stall_locked", 32'(locked), 32'h02);
    end
    next_cyc(); idle_inputs(); set_req(3, 1, 0, 1); set_req(0, 1, 1, 1);
    #2; chk("bp_resume_grant", 32'(grant), 32'h08);
    next_cyc(); idle_inputs(); set_req(0, 1, 1, 1);
    #2; chk("bp_after_grant", 32'(grant), 32'h01); chk("bp_unlocked", 32'(locked), 32'h0);

    // Non-one-hot destination
    next_cyc(); idle_inputs(); req[2] = 1'b1; hdr[2] = 1'b1; tail[2] = 1'b1; dsel[8 +: 4] = 4'b0110;
    #2; chk("bad_grant", 32'(grant), 32'h0); chk("bad_err_same_cycle", 32'(derr), 32'h0);
    next_cyc(); idle_inputs();
    #2; chk("bad_err_set", 32'(derr), 32'h1);
    repeat (3) next_cyc();
    chk("bad_err_sticky", 32'(derr), 32'h1);

    // Reset while output 3 is locked
    next_cyc(); idle_inputs(); set_req(1, 3, 1, 0);
    #2; chk("rst_lock_grant", 32'(grant), 32'h02);
    next_cyc(); idle_inputs();
    #2; chk("rst_locked_before", 32'(locked), 32'h08);
    reset = 1'b0;
    #1;
    chk("rst_locked_cleared", 32'(locked), 32'h0);
    chk("rst_err_cleared", 32'(derr), 32'h0);
    next_cyc(); reset = 1'b1; idle_inputs(); set_req(4, 3, 1, 1); set_req(2, 3, 1, 1);
    #2; chk("rst_ptr0_grant", 32'(grant), 32'h04);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      next_cyc();
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < N; j++) begin
        req[j]  = ($urandom_range(0, 9) < 6);
        hdr[j]  = ($urandom_range(0, 1) == 1);
        tail[j] = ($urandom_range(0, 9) < 4);
        ordy[j] = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 59) == 0) dsel[j*SW +: SW] = 4'($urandom_range(0, 15));
        else                            dsel[j*SW +: SW] = 4'(1 << $urandom_range(0, 3));
      end
    end

    next_cyc();
    idle_inputs();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
